// File: rtl/float_pkg.sv
// Shared binary32 field layout, classification and integer-range constants
// for the float -> signed integer conversion path.
package float_pkg;

  localparam int FLT_EXP_W = 8;
  localparam int FLT_MAN_W = 23;
  localparam int FLT_BIAS  = 127;

  localparam logic [FLT_EXP_W-1:0] EXP_SPECIAL = 8'd255;
  // exp at which the 24-bit significand lands exactly on the integer LSB
  localparam logic [FLT_EXP_W-1:0] EXP_ALIGN   = 8'd150;
  // first exponent whose magnitude reaches 2^31
  localparam logic [FLT_EXP_W-1:0] EXP_INT_LIM = 8'd158;
  localparam logic [7:0]           RSH_FLUSH   = 8'd25;

  localparam logic [31:0] FLT_INT_MIN = 32'hCF00_0000;
  localparam logic [31:0] SAT_POS     = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG     = 32'h8000_0000;

  typedef struct packed {
    logic                 sign;
    logic [FLT_EXP_W-1:0] exp;
    logic [FLT_MAN_W-1:0] frac;
  } float32_t;

  typedef enum logic [1:0] {FC_ZERO, FC_NORM, FC_INF, FC_NAN} fclass_t;

  function automatic fclass_t fp_classify(input float32_t f);
    fclass_t c;
    if (f.exp == '0) begin
      c = FC_ZERO;
    end else if (f.exp == EXP_SPECIAL) begin
      c = (f.frac != '0) ? FC_NAN : FC_INF;
    end else begin
      c = FC_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/float_to_sint32_conv_round.sv
// Round-to-nearest-even of an aligned magnitude followed by sign application.
module fp_rne_round (
  input  logic [31:0] mag,
  input  logic        guard,
  input  logic        sticky,
  input  logic        sign,
  output logic [31:0] result
);

  logic        inc;
  logic [31:0] rounded;

  // ties go to the even neighbour, so an exact half only bumps an odd LSB
  assign inc     = guard & (sticky | mag[0]);
  assign rounded = mag + {31'd0, inc};
  assign result  = sign ? (~rounded + 32'd1) : rounded;

endmodule

// File: rtl/float_to_sint32_conv.sv
// Three-stage binary32 -> sint32 converter (unpack, align, round) with a
// single global stall driven by the output handshake.
module float_to_sint32_conv
  import float_pkg::*;
#(
  parameter logic [31:0] NAN_RESULT = 32'h8000_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_a_tvalid,
  output logic        s_axis_a_tready,
  input  logic [31:0] s_axis_a_tdata,
  output logic        m_axis_result_tvalid,
  input  logic        m_axis_result_tready,
  output logic [31:0] m_axis_result_tdata,
  output logic [1:0]  m_axis_result_tuser
);

  float32_t in_f;
  logic     advance;

  logic        v1_q, v1_d, sign1_q, sign1_d, oor1_q, oor1_d;
  logic [7:0]  exp1_q, exp1_d;
  logic [23:0] man1_q, man1_d;
  fclass_t     cls1_q, cls1_d;

  logic        v2_q, v2_d, sign2_q, sign2_d, guard2_q, guard2_d, sticky2_q, sticky2_d;
  logic        nan2_q, nan2_d, inf2_q, inf2_d, oor2_q, oor2_d;
  logic [31:0] mag2_q, mag2_d;

  logic        v3_q, v3_d;
  logic [31:0] tdata_q, tdata_d;
  logic [1:0]  tuser_q, tuser_d;

  logic [7:0]  rsh;
  logic [3:0]  lsh;
  logic [4:0]  rsh_lo;
  logic [23:0] low_mask;
  logic [31:0] rnd_result;

  assign in_f            = float32_t'(s_axis_a_tdata);
  assign advance         = ~v3_q | m_axis_result_tready;
  assign s_axis_a_tready = advance;

  always_comb begin
    v1_d    = v1_q;
    sign1_d = sign1_q;
    exp1_d  = exp1_q;
    man1_d  = man1_q;
    cls1_d  = cls1_q;
    oor1_d  = oor1_q;
    if (advance) begin
      v1_d = s_axis_a_tvalid;
      if (s_axis_a_tvalid) begin
        sign1_d = in_f.sign;
        exp1_d  = in_f.exp;
        man1_d  = {1'b1, in_f.frac};
        cls1_d  = fp_classify(in_f);
        // -2^31 is the single finite value at the limit exponent that still fits
        oor1_d  = (fp_classify(in_f) == FC_NORM) && (in_f.exp >= EXP_INT_LIM) &&
                  (s_axis_a_tdata != FLT_INT_MIN);
      end
    end
  end

  assign rsh      = EXP_ALIGN - exp1_q;
  assign lsh      = 4'(exp1_q - EXP_ALIGN);
  assign rsh_lo   = rsh[4:0];
  assign low_mask = (24'd1 << (rsh_lo - 5'd1)) - 24'd1;

  always_comb begin
    v2_d      = v2_q;
    sign2_d   = sign2_q;
    mag2_d    = mag2_q;
    guard2_d  = guard2_q;
    sticky2_d = sticky2_q;
    nan2_d    = nan2_q;
    inf2_d    = inf2_q;
    oor2_d    = oor2_q;
    if (advance) begin
      v2_d = v1_q;
      if (v1_q) begin
        sign2_d   = sign1_q;
        nan2_d    = (cls1_q == FC_NAN);
        inf2_d    = (cls1_q == FC_INF);
        oor2_d    = oor1_q;
        mag2_d    = '0;
        guard2_d  = 1'b0;
        sticky2_d = 1'b0;
        if (cls1_q == FC_NORM && !oor1_q) begin
          if (exp1_q >= EXP_ALIGN) begin
            mag2_d = {8'd0, man1_q} << lsh;
          end else if (rsh >= RSH_FLUSH) begin
            sticky2_d = 1'b1;
          end else begin
            mag2_d    = {8'd0, man1_q >> rsh_lo};
            guard2_d  = man1_q[rsh_lo - 5'd1];
            sticky2_d = |(man1_q & low_mask);
          end
        end
      end
    end
  end

  fp_rne_round u_round (
    .mag    (mag2_q),
    .guard  (guard2_q),
    .sticky (sticky2_q),
    .sign   (sign2_q),
    .result (rnd_result)
  );

  always_comb begin
    v3_d    = v3_q;
    tdata_d = tdata_q;
    tuser_d = tuser_q;
    if (advance) begin
      v3_d = v2_q;
      if (v2_q) begin
        if (nan2_q) begin
          tdata_d = NAN_RESULT;
          tuser_d = 2'b10;
        end else if (inf2_q) begin
          tdata_d = sign2_q ? SAT_NEG : SAT_POS;
          tuser_d = 2'b10;
        end else if (oor2_q) begin
          tdata_d = sign2_q ? SAT_NEG : SAT_POS;
          tuser_d = 2'b01;
        end else begin
          tdata_d = rnd_result;
          tuser_d = 2'b00;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v1_q      <= 1'b0;
      sign1_q   <= 1'b0;
      exp1_q    <= '0;
      man1_q    <= '0;
      cls1_q    <= FC_ZERO;
      oor1_q    <= 1'b0;
      v2_q      <= 1'b0;
      sign2_q   <= 1'b0;
      mag2_q    <= '0;
      guard2_q  <= 1'b0;
      sticky2_q <= 1'b0;
      nan2_q    <= 1'b0;
      inf2_q    <= 1'b0;
      oor2_q    <= 1'b0;
      v3_q      <= 1'b0;
      tdata_q   <= '0;
      tuser_q   <= '0;
    end else begin
      v1_q      <= v1_d;
      sign1_q   <= sign1_d;
      exp1_q    <= exp1_d;
      man1_q    <= man1_d;
      cls1_q    <= cls1_d;
      oor1_q    <= oor1_d;
      v2_q      <= v2_d;
      sign2_q   <= sign2_d;
      mag2_q    <= mag2_d;
      guard2_q  <= guard2_d;
      sticky2_q <= sticky2_d;
      nan2_q    <= nan2_d;
      inf2_q    <= inf2_d;
      oor2_q    <= oor2_d;
      v3_q      <= v3_d;
      tdata_q   <= tdata_d;
      tuser_q   <= tuser_d;
    end
  end

  assign m_axis_result_tvalid = v3_q;
  assign m_axis_result_tdata  = tdata_q;
  assign m_axis_result_tuser  = tuser_q;

endmodule
